pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_target_adder.sv | 19 +
 rtl/pc_sequencer.sv | 76 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding
// and the constants used to step and count control flow.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_t;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INC = 4;

  // Saturation ceiling of the taken-transfer counter.
  localparam logic [7:0] TAKEN_MAX = 8'hFF;

endpackage

// File: rtl/pc_target_adder.sv
// Branch/jump target generator: TARGET = PC_PLUS4 + (sext(OFFSET) << 2).
// The offset counts instructions (words), so it is scaled to bytes before the
// add; the sum wraps naturally at PC_WIDTH bits.
module pc_target_adder #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic [7:0]          offset,
  output logic [PC_WIDTH-1:0] target
);

  logic [PC_WIDTH-1:0] byte_offset;

  // Sign-extend the word offset and scale it to a byte offset.
  assign byte_offset = {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};

  assign target = pc_plus4 + byte_offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. After reset the FSM spends one cycle in BOOT,
// then steps the PC each cycle in RUN (sequential or taken transfer) until a
// halt instruction parks it in HALTED. STALL freezes everything while in RUN.
// Priority of controls: reset > stall > halt > flow_select.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(32'h0000_0000)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flow_select,
  input  logic [7:0]          offset,
  input  logic                stall,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                instr_valid,
  output logic [7:0]          taken_count
);

  seq_state_t          state;
  logic [PC_WIDTH-1:0] target;

  assign pc_plus4 = pc + PC_WIDTH'(PC_INC);

  pc_target_adder #(
    .PC_WIDTH (PC_WIDTH)
  ) u_target_adder (
    .pc_plus4 (pc_plus4),
    .offset   (offset),
    .target   (target)
  );

  // FSM, PC register, registered instr_valid and saturating taken counter.
  // NOTE: state registers use non-blocking assignments so every register in
  // this block sees the pre-edge values of the others, exactly as the flops do.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      taken_count <= '0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: begin
          // One settling cycle; PC stays at the reset vector.
          state       <= ST_RUN;
          instr_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!stall) begin
            if (halt) begin
              state       <= ST_HALTED;
              instr_valid <= 1'b0;
            end else begin
              pc <= flow_select ? target : pc_plus4;
              if (flow_select && (taken_count != TAKEN_MAX)) begin
                taken_count <= taken_count + 8'd1;
              end
            end
          end
        end
        ST_HALTED: begin
          // Parked until reset; all inputs ignored.
        end
        default: begin
          state       <= ST_BOOT;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
